pci_target_burst: RTL and testbench

Parametrised PCI memory target that replaces the single-word, externally-sequenced target controller. It decodes its own transactions from FRAME_n/C_BE, claims a configurable address window, and services burst memory reads and writes against an internal word array with byte enables, programmable initial wait states and target disconnect at the window end. It sits directly on the shared AD/C_BE bus beside the arbiter and master controllers.

---
 rtl/pci_pkg.sv | 36 +++
 rtl/pci_target_mem_array.sv | 31 +++
 rtl/pci_target_burst.sv | 133 +++++++++++++
 tb/tb_pci_target_burst.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
// pci_pkg : command codes, FSM state encoding and bus level constants shared
//           by the PCI target, master and arbiter blocks.   Rev 1.0
// ============================================================================
package pci_pkg;

  typedef logic [3:0] pci_cmd_t;

  localparam pci_cmd_t CMD_MEM_READ      = 4'b0110;
  localparam pci_cmd_t CMD_MEM_WRITE     = 4'b0111;
  localparam pci_cmd_t CMD_MEM_READ_MULT = 4'b1100;
  localparam pci_cmd_t CMD_MEM_READ_LINE = 4'b1110;
  localparam pci_cmd_t CMD_MEM_WRITE_INV = 4'b1111;

  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_TURN   = 3'd5;
  localparam logic [2:0] ST_BUSY   = 3'd6;

  function automatic logic is_read_cmd(input pci_cmd_t cmd);
    return cmd inside {CMD_MEM_READ, CMD_MEM_READ_MULT, CMD_MEM_READ_LINE};
  endfunction

  function automatic logic is_write_cmd(input pci_cmd_t cmd);
    return cmd inside {CMD_MEM_WRITE, CMD_MEM_WRITE_INV};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pci_target_mem_array.sv
`default_nettype none
// ============================================================================
// pci_target_mem_array : 2^DEPTH_LOG2 x 32 word array, byte-enable write,
//                        asynchronous read.   Rev 1.0
// ============================================================================
module pci_target_mem_array #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  // Contents are deliberately not reset; only the written lanes change.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/pci_target_burst.sv
`default_nettype none
// ============================================================================
// pci_target_burst : self-decoding PCI memory target with burst transfers,
//                    initial wait states and last-word disconnect.   Rev 1.0
// ============================================================================
module pci_target_burst
  import pci_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH_LOG2  = 3,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] AD,
  input  logic [3:0]  C_BE,
  input  logic        FRAME_n,
  input  logic        IRDY_n,
  output wire         DEVSEL_n,
  output wire         TRDY_n,
  output wire         STOP_n
);

  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  logic [2:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic                  is_wr_q, is_wr_d;

  logic        hit, xfer, at_last, own, ad_oe, mem_we;
  logic        devsel_v, trdy_v, stop_v;
  logic [31:0] rdata;

  assign hit = (AD[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]) &&
               (is_read_cmd(C_BE) || is_write_cmd(C_BE));

  assign at_last = (idx_q == LAST_IDX);
  // TRDY_n is always asserted in DATA, so IRDY_n alone qualifies a transfer.
  assign xfer    = (state_q == ST_DATA) && (IRDY_n == ASSERT_N);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    is_wr_d = is_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (FRAME_n == ASSERT_N) begin
          idx_d   = AD[DEPTH_LOG2+1:2];
          is_wr_d = is_write_cmd(C_BE);
          state_d = hit ? ST_DECODE : ST_BUSY;
        end
      end
      ST_DECODE: begin
        if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          wcnt_d  = 3'(WAIT_STATES);
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WAIT: begin
        if (wcnt_q <= 3'd1) begin
          state_d = ST_DATA;
          wcnt_d  = 3'd0;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          if (FRAME_n == DEASSERT_N) state_d = ST_TURN;
          else if (at_last)          state_d = ST_STOP;
          else                       idx_d   = idx_q + DEPTH_LOG2'(1);
        end
      end
      ST_STOP: begin
        if (FRAME_n == DEASSERT_N) state_d = ST_TURN;
      end
      ST_TURN: state_d = ST_IDLE;
      ST_BUSY: begin
        if (FRAME_n == DEASSERT_N && IRDY_n == DEASSERT_N) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wcnt_q  <= 3'd0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      is_wr_q <= is_wr_d;
    end
  end

  // A write phase coinciding with reset is dropped.
  assign mem_we = xfer && is_wr_q && !rst;

  pci_target_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (idx_q),
    .be_i   (~C_BE),
    .wdata_i(AD),
    .rdata_o(rdata)
  );

  assign own = state_q inside {ST_DECODE, ST_WAIT, ST_DATA, ST_STOP, ST_TURN};

  assign devsel_v = (state_q == ST_TURN) ? DEASSERT_N : ASSERT_N;
  assign trdy_v   = (state_q == ST_DATA) ? ASSERT_N : DEASSERT_N;
  assign stop_v   = ((state_q == ST_STOP) || (state_q == ST_DATA && at_last)) ?
                    ASSERT_N : DEASSERT_N;

  assign DEVSEL_n = own ? devsel_v : 1'bz;
  assign TRDY_n   = own ? trdy_v   : 1'bz;
  assign STOP_n   = own ? stop_v   : 1'bz;

  // DECODE is the read turnaround cycle, so AD is first driven in WAIT.
  assign ad_oe = !is_wr_q && (state_q == ST_WAIT || state_q == ST_DATA);
  assign AD    = ad_oe ? rdata : 32'bz;

endmodule
`default_nettype wire

// File: tb/tb_pci_target_burst.sv
`default_nettype none
// ============================================================================
// tb_pci_target_burst : directed master-side bench for pci_target_burst
//                       (BASE 0x1000, 8 words, 1 wait state).   Rev 1.0
// ============================================================================
module tb_pci_target_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  c_be;
  logic        frame_n, irdy_n;
  logic        m_oe;
  logic [31:0] m_ad;
  wire  [31:0] ad;
  wire         devsel_n, trdy_n, stop_n;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wbuf [8];
  logic [31:0] rbuf [8];

  assign ad = m_oe ? m_ad : 32'bz;
  // Shared-bus control lines are pulled up, so a released line reads 1.
  pullup (devsel_n);
  pullup (trdy_n);
  pullup (stop_n);

  always #5 clk = ~clk;

  pci_target_burst #(
    .BASE_ADDR  (32'h0000_1000),
    .DEPTH_LOG2 (3),
    .WAIT_STATES(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .AD      (ad),
    .C_BE    (c_be),
    .FRAME_n (frame_n),
    .IRDY_n  (irdy_n),
    .DEVSEL_n(devsel_n),
    .TRDY_n  (trdy_n),
    .STOP_n  (stop_n)
  );

  function automatic bit ad_released();
    return $isunknown(ad) || (ad == 32'h0);
  endfunction

  task automatic bus_write(input logic [31:0] addr, input int n, input logic [3:0] be);
    int cnt;
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; m_oe = 1'b1; m_ad = addr; c_be = 4'b0111;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      m_ad = wbuf[i]; c_be = be; irdy_n = 1'b0;
      if (i == n - 1) frame_n = 1'b1;
      cnt = 0;
      while (trdy_n !== 1'b0 && cnt < 16) begin @(negedge clk); cnt++; end
      if (cnt == 16) begin
        n_cmp++; n_bad++;
        $display("FAIL write_trdy_timeout: phase %0d got no TRDY_n within 16 cycles", i);
      end
      @(negedge clk);
    end
    frame_n = 1'b1; irdy_n = 1'b1; m_oe = 1'b0; c_be = 4'hF;
  endtask

  task automatic bus_read(input logic [31:0] addr, input int n);
    int cnt;
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; m_oe = 1'b1; m_ad = addr; c_be = 4'b0110;
    @(negedge clk);
    m_oe = 1'b0; c_be = 4'h0; irdy_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) frame_n = 1'b1;
      cnt = 0;
      while (trdy_n !== 1'b0 && cnt < 16) begin @(negedge clk); cnt++; end
      if (cnt == 16) begin
        n_cmp++; n_bad++;
        $display("FAIL read_trdy_timeout: phase %0d got no TRDY_n within 16 cycles", i);
        rbuf[i] = 32'h0;
      end else begin
        rbuf[i] = ad;
      end
      @(negedge clk);
    end
    frame_n = 1'b1; irdy_n = 1'b1; c_be = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({devsel_n, trdy_n, stop_n} !== 3'b111) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 111", {devsel_n, trdy_n, stop_n});
    end
    n_cmp++;
    if (!ad_released()) begin
      n_bad++; $display("FAIL reset_ad: got %h expected released", ad);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_burst();
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; m_oe = 1'b1; m_ad = 32'h1000; c_be = 4'b0111;
    @(negedge clk);
    n_cmp++;
    if ({devsel_n, trdy_n, stop_n} !== 3'b011) begin
      n_bad++; $display("FAIL wr_devsel_t1: got %b expected 011", {devsel_n, trdy_n, stop_n});
    end
    m_ad = 32'h1111_1111; c_be = 4'h0; irdy_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({devsel_n, trdy_n, stop_n} !== 3'b011) begin
      n_bad++; $display("FAIL wr_wait_t2: got %b expected 011", {devsel_n, trdy_n, stop_n});
    end
    @(negedge clk);
    n_cmp++;
    if ({devsel_n, trdy_n, stop_n} !== 3'b001) begin
      n_bad++; $display("FAIL wr_first_trdy_t3: got %b expected 001", {devsel_n, trdy_n, stop_n});
    end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      m_ad = 32'h1111_1111 * 32'(k);
      if (k == 4) frame_n = 1'b1;
      n_cmp++;
      if ({devsel_n, trdy_n, stop_n} !== 3'b001) begin
        n_bad++; $display("FAIL wr_data_%0d: got %b expected 001", k, {devsel_n, trdy_n, stop_n});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({devsel_n, trdy_n, stop_n} !== 3'b111) begin
      n_bad++; $display("FAIL wr_turn: got %b expected 111", {devsel_n, trdy_n, stop_n});
    end
    frame_n = 1'b1; irdy_n = 1'b1; m_oe = 1'b0; c_be = 4'hF;
    bus_read(32'h1000, 4);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rbuf[k] !== 32'h1111_1111 * 32'(k + 1)) begin
        n_bad++; $display("FAIL wr_readback_%0d: got %h expected %h", k, rbuf[k], 32'h1111_1111 * 32'(k + 1));
      end
    end
  endtask

  task automatic test_byte_enable();
    wbuf[0] = 32'hDEAD_BEEF;
    bus_write(32'h1004, 1, 4'b1010);
    bus_read(32'h1000, 3);
    n_cmp++;
    if (rbuf[0] !== 32'h1111_1111) begin
      n_bad++; $display("FAIL be_word0: got %h expected 11111111", rbuf[0]);
    end
    n_cmp++;
    if (rbuf[1] !== 32'h22AD_22EF) begin
      n_bad++; $display("FAIL be_word1: got %h expected 22ad22ef", rbuf[1]);
    end
    n_cmp++;
    if (rbuf[2] !== 32'h3333_3333) begin
      n_bad++; $display("FAIL be_word2: got %h expected 33333333", rbuf[2]);
    end
  endtask

  task automatic test_stop_disconnect();
    wbuf[0] = 32'h6666_6666; wbuf[1] = 32'h7777_7777;
    bus_write(32'h1018, 2, 4'h0);
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; m_oe = 1'b1; m_ad = 32'h1018; c_be = 4'b1100;
    @(negedge clk);
    m_oe = 1'b0; c_be = 4'h0; irdy_n = 1'b0;
    #1;
    n_cmp++;
    if (!ad_released() || {devsel_n, trdy_n, stop_n} !== 3'b011) begin
      n_bad++; $display("FAIL rd_decode: got ad=%h ctrl=%b expected released/011", ad, {devsel_n, trdy_n, stop_n});
    end
    @(negedge clk);
    n_cmp++;
    if (ad !== 32'h6666_6666 || {devsel_n, trdy_n, stop_n} !== 3'b011) begin
      n_bad++; $display("FAIL rd_wait: got ad=%h ctrl=%b expected 66666666/011", ad, {devsel_n, trdy_n, stop_n});
    end
    @(negedge clk);
    n_cmp++;
    if (ad !== 32'h6666_6666 || {devsel_n, trdy_n, stop_n} !== 3'b001) begin
      n_bad++; $display("FAIL rd_word6: got ad=%h ctrl=%b expected 66666666/001", ad, {devsel_n, trdy_n, stop_n});
    end
    @(negedge clk);
    n_cmp++;
    if (ad !== 32'h7777_7777 || {devsel_n, trdy_n, stop_n} !== 3'b000) begin
      n_bad++; $display("FAIL rd_word7_stop: got ad=%h ctrl=%b expected 77777777/000", ad, {devsel_n, trdy_n, stop_n});
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({devsel_n, trdy_n, stop_n} !== 3'b010) begin
        n_bad++; $display("FAIL rd_stop_hold_%0d: got %b expected 010", k, {devsel_n, trdy_n, stop_n});
      end
    end
    frame_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (!ad_released() || {devsel_n, trdy_n, stop_n} !== 3'b111) begin
      n_bad++; $display("FAIL rd_turn: got ad=%h ctrl=%b expected released/111", ad, {devsel_n, trdy_n, stop_n});
    end
    irdy_n = 1'b1; c_be = 4'hF;
    @(negedge clk);
    n_cmp++;
    if (!ad_released() || {devsel_n, trdy_n, stop_n} !== 3'b111) begin
      n_bad++; $display("FAIL rd_idle_after_turn: got ad=%h ctrl=%b expected released/111", ad, {devsel_n, trdy_n, stop_n});
    end
  endtask

  task automatic test_miss(input logic [31:0] addr, input logic [3:0] cmd);
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; m_oe = 1'b1; m_ad = addr; c_be = cmd;
    @(negedge clk);
    m_oe = 1'b0; c_be = 4'h0; irdy_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (!ad_released() || {devsel_n, trdy_n, stop_n} !== 3'b111) begin
        n_bad++; $display("FAIL miss_%h_%b_c%0d: got ad=%h ctrl=%b expected released/111", addr, cmd, k, ad, {devsel_n, trdy_n, stop_n});
      end
      if (k == 2) frame_n = 1'b1;
      @(negedge clk);
    end
    irdy_n = 1'b1; c_be = 4'hF;
    @(negedge clk);
  endtask

  task automatic test_irdy_wait();
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; m_oe = 1'b1; m_ad = 32'h1000; c_be = 4'b0110;
    @(negedge clk);
    m_oe = 1'b0; c_be = 4'h0; irdy_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (ad !== 32'h1111_1111) begin
      n_bad++; $display("FAIL irdy_word0: got %h expected 11111111", ad);
    end
    @(negedge clk);
    n_cmp++;
    if (ad !== 32'h22AD_22EF) begin
      n_bad++; $display("FAIL irdy_word1: got %h expected 22ad22ef", ad);
    end
    irdy_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (ad !== 32'h22AD_22EF || {devsel_n, trdy_n, stop_n} !== 3'b001) begin
        n_bad++; $display("FAIL irdy_hold_%0d: got ad=%h ctrl=%b expected 22ad22ef/001", k, ad, {devsel_n, trdy_n, stop_n});
      end
    end
    irdy_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ad !== 32'h3333_3333) begin
      n_bad++; $display("FAIL irdy_resume: got %h expected 33333333", ad);
    end
    frame_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({devsel_n, trdy_n, stop_n} !== 3'b111) begin
      n_bad++; $display("FAIL irdy_turn: got %b expected 111", {devsel_n, trdy_n, stop_n});
    end
    irdy_n = 1'b1; c_be = 4'hF;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    frame_n = 1'b0; irdy_n = 1'b1; m_oe = 1'b1; m_ad = 32'h1000; c_be = 4'b0111;
    @(negedge clk);
    m_ad = 32'hA5A5_A5A5; c_be = 4'h0; irdy_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({devsel_n, trdy_n, stop_n} !== 3'b001) begin
      n_bad++; $display("FAIL rstmid_data: got %b expected 001", {devsel_n, trdy_n, stop_n});
    end
    @(negedge clk);
    m_ad = 32'h5A5A_5A5A; rst = 1'b1;
    @(negedge clk);
    m_oe = 1'b0;
    #1;
    n_cmp++;
    if (!ad_released() || {devsel_n, trdy_n, stop_n} !== 3'b111) begin
      n_bad++; $display("FAIL rstmid_released: got ad=%h ctrl=%b expected released/111", ad, {devsel_n, trdy_n, stop_n});
    end
    rst = 1'b0; frame_n = 1'b1; irdy_n = 1'b1; c_be = 4'hF;
    bus_read(32'h1000, 2);
    n_cmp++;
    if (rbuf[0] !== 32'hA5A5_A5A5) begin
      n_bad++; $display("FAIL rstmid_word0: got %h expected a5a5a5a5", rbuf[0]);
    end
    n_cmp++;
    if (rbuf[1] !== 32'h22AD_22EF) begin
      n_bad++; $display("FAIL rstmid_word1_dropped: got %h expected 22ad22ef", rbuf[1]);
    end
  endtask

  initial begin
    rst = 1'b1; frame_n = 1'b1; irdy_n = 1'b1; m_oe = 1'b0; m_ad = 32'h0; c_be = 4'hF;
    test_reset();
    test_write_burst();
    test_byte_enable();
    test_stop_disconnect();
    test_miss(32'h2000, 4'b0110);
    test_miss(32'h1000, 4'b0010);
    test_irdy_wait();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
